// File: rtl/tracer_pkg.sv
// Shared widths and helpers for the tracer ROI accumulator blocks.
package tracer_pkg;
  localparam int TRACER_NUM_ROI  = 64;
  localparam int TRACER_ROI_ID_W = 6;
  localparam int TRACER_ACC_W    = 16;
  localparam int TRACER_PIX_W    = 8;

  typedef logic [TRACER_ROI_ID_W-1:0] roi_id_t;

  // Dump index advance with wrap at the last bin.
  function automatic roi_id_t tracer_next_idx(input roi_id_t idx, input int num_roi);
    return (idx == roi_id_t'(num_roi - 1)) ? '0 : idx + roi_id_t'(1);
  endfunction
endpackage

// File: rtl/tracer_acc_bank.sv
// NUM_ROI x ACC_W bin register file: one accumulate port, one read-clear port, global clear.
// TRACER_ACC_SATURATE_EN: clamp adds at all-ones instead of wrapping.
module tracer_acc_bank
  import tracer_pkg::*;
#(
  parameter int NUM_ROI = TRACER_NUM_ROI,
  parameter int PIX_W   = TRACER_PIX_W,
  parameter int ACC_W   = TRACER_ACC_W
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             acc_en_i,
  input  roi_id_t          acc_id_i,
  input  logic [PIX_W-1:0] acc_add_i,
  input  roi_id_t          rd_idx_i,
  input  logic             rd_clr_i,
  input  logic             gclr_i,
  output logic [ACC_W-1:0] rd_data_o,
  output logic             ovf_o
);
  logic [NUM_ROI-1:0][ACC_W-1:0] bin_q;
  logic [ACC_W:0]                sum;
  logic [ACC_W-1:0]              acc_nxt;

  assign sum = {1'b0, bin_q[acc_id_i]} + (ACC_W+1)'(acc_add_i);

`ifdef TRACER_ACC_SATURATE_EN
  assign acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  assign ovf_o     = acc_en_i & sum[ACC_W];
  assign rd_data_o = bin_q[rd_idx_i];

  // Clears beat accumulation on the same bin.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      bin_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ROI; i++) begin
        if (gclr_i || (rd_clr_i && rd_idx_i == roi_id_t'(i)))
          bin_q[i] <= '0;
        else if (acc_en_i && acc_id_i == roi_id_t'(i))
          bin_q[i] <= acc_nxt;
      end
    end
  end
endmodule

// File: rtl/tracer_roi_accumulator.sv
// Per-frame ROI trace accumulator with read-and-clear dump toward the trace store.
// TRACER_ACC_SATURATE_EN selects saturating bins (default: wrapping bins).
module tracer_roi_accumulator
  import tracer_pkg::*;
#(
  parameter int NUM_ROI = TRACER_NUM_ROI,
  parameter int PIX_W   = TRACER_PIX_W,
  parameter int ACC_W   = TRACER_ACC_W
) (
  input  logic                       s_axi_aclk,
  input  logic                       s_axi_aresetn,
  input  logic                       frame_start,
  input  logic                       pix_valid,
  input  logic [PIX_W-1:0]           pix_data,
  input  logic                       pix_roi_hit,
  input  logic [TRACER_ROI_ID_W-1:0] pix_roi_id,
  input  logic                       store_trace,
  output logic [ACC_W-1:0]           acc_trace,
  output logic                       dump_active,
  output logic                       acc_ovf,
  output logic                       pix_drop
);
  logic             stg_vld_q;
  roi_id_t          stg_id_q;
  logic [PIX_W-1:0] stg_data_q;
  roi_id_t          rd_idx_q, rd_idx_d;
  logic             dump_q, ovf_q, ovf_d, drop_q, drop_d;
  logic             pix_take, pix_rej, hazard, commit, bank_ovf;

  assign pix_take = pix_valid & pix_roi_hit & ~store_trace;
  assign pix_rej  = pix_valid & pix_roi_hit & store_trace;
  // Staged pixel aimed at the bin being read-cleared this edge is lost.
  assign hazard   = stg_vld_q & store_trace & (rd_idx_q == stg_id_q);
  assign commit   = stg_vld_q & ~frame_start & ~hazard;

  always_comb begin
    rd_idx_d = store_trace ? tracer_next_idx(rd_idx_q, NUM_ROI) : '0;
    ovf_d    = (frame_start ? 1'b0 : ovf_q) | bank_ovf;
    drop_d   = (frame_start ? 1'b0 : drop_q) | pix_rej | (hazard & ~frame_start);
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      stg_vld_q  <= 1'b0;
      stg_id_q   <= '0;
      stg_data_q <= '0;
      rd_idx_q   <= '0;
      dump_q     <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      stg_vld_q <= pix_take;
      if (pix_take) begin
        stg_id_q   <= pix_roi_id;
        stg_data_q <= pix_data;
      end
      rd_idx_q <= rd_idx_d;
      dump_q   <= store_trace;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  tracer_acc_bank #(
    .NUM_ROI (NUM_ROI),
    .PIX_W   (PIX_W),
    .ACC_W   (ACC_W)
  ) u_bank (
    .gclk      (s_axi_aclk),
    .grst_n    (s_axi_aresetn),
    .acc_en_i  (commit),
    .acc_id_i  (stg_id_q),
    .acc_add_i (stg_data_q),
    .rd_idx_i  (rd_idx_q),
    .rd_clr_i  (store_trace),
    .gclr_i    (frame_start),
    .rd_data_o (acc_trace),
    .ovf_o     (bank_ovf)
  );

  assign dump_active = dump_q;
  assign acc_ovf     = ovf_q;
  assign pix_drop    = drop_q;
endmodule
